// File: rtl/bp_me_nonsynth_tr_dispatch.sv
// bp_me_nonsynth_tr_dispatch: serializes trace packets into single-outstanding cache requests and checks load responses
module bp_me_nonsynth_tr_dispatch #(
  parameter int paddr_width_p = 40,
  parameter int data_width_p = 64,
  parameter int timeout_p = 1024,
  localparam int tr_pkt_width_lp = 4 + paddr_width_p + 1 + data_width_p
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [tr_pkt_width_lp-1:0] tr_pkt_i,
  input  logic                       tr_v_i,
  output logic                       tr_ready_and_o,
  input  logic                       tr_done_i,
  output logic [3:0]                 req_cmd_o,
  output logic [paddr_width_p-1:0]   req_paddr_o,
  output logic                       req_uncached_o,
  output logic [data_width_p-1:0]    req_data_o,
  output logic                       req_v_o,
  input  logic                       req_ready_and_i,
  input  logic [data_width_p-1:0]    resp_data_i,
  input  logic                       resp_v_i,
  output logic                       done_o,
  output logic                       error_o,
  output logic                       timeout_o,
  output logic [31:0]                issued_cnt_o,
  output logic [31:0]                mismatch_cnt_o
);
  typedef enum logic [2:0] {e_idle, e_send, e_wait, e_done, e_timeout} state_e;
  state_e state_r, state_n;
  logic [tr_pkt_width_lp-1:0] pkt_r;
  logic [31:0] tcnt_r, issued_r, mis_r;
  logic error_r, accept, hs, resp_ok, unexp, bad_ld, expired;
  always_comb begin
    accept = state_r == e_idle && tr_v_i;
    hs = state_r == e_send && req_ready_and_i;
    resp_ok = state_r == e_wait && resp_v_i;
    unexp = resp_v_i && state_r != e_wait;
    bad_ld = resp_ok && !req_cmd_o[3] && resp_data_i != req_data_o;
    expired = ((state_r == e_send && !req_ready_and_i) || (state_r == e_wait && !resp_v_i))
              && tcnt_r >= 32'(timeout_p - 1);
    state_n = accept ? e_send
            : (state_r == e_idle && tr_done_i) ? e_done
            : expired ? e_timeout
            : hs ? e_wait
            : resp_ok ? e_idle
            : state_r;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_idle;
      pkt_r <= '0;
      tcnt_r <= '0;
      issued_r <= '0;
      mis_r <= '0;
      error_r <= 1'b0;
    end else begin
      state_r <= state_n;
      if (accept) pkt_r <= tr_pkt_i;
      tcnt_r <= accept ? '0 : (state_r == e_send || state_r == e_wait) ? tcnt_r + 32'd1 : tcnt_r;
      issued_r <= issued_r + 32'(hs && issued_r != '1);
      mis_r <= mis_r + 32'((bad_ld || unexp) && mis_r != '1);
      error_r <= error_r || bad_ld || unexp || expired;
    end
  end
  assign {req_cmd_o, req_paddr_o, req_uncached_o, req_data_o} = pkt_r;
  assign tr_ready_and_o = state_r == e_idle;
  assign req_v_o = state_r == e_send;
  assign done_o = state_r == e_done;
  assign timeout_o = state_r == e_timeout;
  assign error_o = error_r;
  assign issued_cnt_o = issued_r;
  assign mismatch_cnt_o = mis_r;
endmodule

// File: tb/tb_bp_me_nonsynth_tr_dispatch.sv
// tb_bp_me_nonsynth_tr_dispatch: directed self-checking bench for the trace dispatcher
module tb_bp_me_nonsynth_tr_dispatch;
  logic clk = 1'b0, reset_i, tr_v_i, tr_done_i, req_ready_and_i, resp_v_i;
  logic [108:0] tr_pkt_i;
  logic [63:0] resp_data_i, req_data_o;
  logic [39:0] req_paddr_o;
  logic [3:0] req_cmd_o;
  logic tr_ready_and_o, req_uncached_o, req_v_o, done_o, error_o, timeout_o;
  logic [31:0] issued_cnt_o, mismatch_cnt_o;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  bp_me_nonsynth_tr_dispatch #(.timeout_p(16)) dut (
    .clk_i(clk), .reset_i(reset_i), .tr_pkt_i(tr_pkt_i), .tr_v_i(tr_v_i),
    .tr_ready_and_o(tr_ready_and_o), .tr_done_i(tr_done_i), .req_cmd_o(req_cmd_o),
    .req_paddr_o(req_paddr_o), .req_uncached_o(req_uncached_o), .req_data_o(req_data_o),
    .req_v_o(req_v_o), .req_ready_and_i(req_ready_and_i), .resp_data_i(resp_data_i),
    .resp_v_i(resp_v_i), .done_o(done_o), .error_o(error_o), .timeout_o(timeout_o),
    .issued_cnt_o(issued_cnt_o), .mismatch_cnt_o(mismatch_cnt_o)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
  endtask
  task automatic run_op(input string tag, input logic [3:0] c, input logic [39:0] a,
                        input logic [63:0] d, input logic [63:0] rd);
    tr_pkt_i = {c, a, 1'b0, d};
    tr_v_i = 1'b1;
    tick();
    tr_v_i = 1'b0;
    chk({tag, "_req_v"}, req_v_o, 1);
    chk({tag, "_cmd"}, req_cmd_o, c);
    chk({tag, "_paddr"}, req_paddr_o, a);
    if (c[3]) chk({tag, "_data"}, req_data_o, d);
    tick();
    chk({tag, "_req_v_drop"}, req_v_o, 0);
    resp_v_i = 1'b1;
    resp_data_i = rd;
    tick();
    resp_v_i = 1'b0;
    chk({tag, "_ready"}, tr_ready_and_o, 1);
  endtask
  initial begin
    reset_i = 1'b1;
    tr_v_i = 1'b0;
    tr_done_i = 1'b0;
    req_ready_and_i = 1'b1;
    resp_v_i = 1'b0;
    resp_data_i = '0;
    tr_pkt_i = '0;
    tick();
    tick();
    reset_i = 1'b0;
    chk("rst_ready", tr_ready_and_o, 1);
    chk("rst_req_v", req_v_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_error", error_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_issued", issued_cnt_o, 0);
    chk("rst_mis", mismatch_cnt_o, 0);
    run_op("ld1", 4'b0011, 40'h80000000, 64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D);
    chk("ld1_issued", issued_cnt_o, 1);
    chk("ld1_mis", mismatch_cnt_o, 0);
    tr_done_i = 1'b1;
    tick();
    tr_done_i = 1'b0;
    chk("ld1_done", done_o, 1);
    chk("ld1_err", error_o, 0);
    chk("ld1_ready", tr_ready_and_o, 0);
    do_reset();
    run_op("sd", 4'b1011, 40'h80000040, 64'h11223344_55667788, 64'h0);
    run_op("ld2", 4'b0011, 40'h80000040, 64'h11223344_55667788, 64'h11223344_55667788);
    chk("sdld_issued", issued_cnt_o, 2);
    chk("sdld_mis", mismatch_cnt_o, 0);
    chk("sdld_err", error_o, 0);
    run_op("lbu", 4'b0100, 40'h80000080, 64'hFF, 64'hFFFFFFFF_FFFFFFFF);
    chk("lbu_mis", mismatch_cnt_o, 1);
    chk("lbu_err", error_o, 1);
    run_op("ld3", 4'b0011, 40'h800000C0, 64'h5, 64'h5);
    chk("ld3_issued", issued_cnt_o, 4);
    chk("ld3_mis", mismatch_cnt_o, 1);
    do_reset();
    resp_v_i = 1'b1;
    tick();
    resp_v_i = 1'b0;
    chk("unexp_mis", mismatch_cnt_o, 1);
    chk("unexp_err", error_o, 1);
    chk("unexp_ready", tr_ready_and_o, 1);
    tr_pkt_i = {4'b0011, 40'h80000100, 1'b0, 64'h7};
    tr_v_i = 1'b1;
    tick();
    tr_v_i = 1'b0;
    tick();
    chk("mid_issued", issued_cnt_o, 1);
    do_reset();
    chk("mid_rst_issued", issued_cnt_o, 0);
    chk("mid_rst_mis", mismatch_cnt_o, 0);
    chk("mid_rst_err", error_o, 0);
    chk("mid_rst_ready", tr_ready_and_o, 1);
    resp_v_i = 1'b1;
    resp_data_i = 64'h7;
    tick();
    resp_v_i = 1'b0;
    chk("late_mis", mismatch_cnt_o, 1);
    do_reset();
    tr_pkt_i = {4'b0011, 40'h80000200, 1'b0, 64'hABCD};
    tr_v_i = 1'b1;
    tr_done_i = 1'b1;
    tick();
    tr_v_i = 1'b0;
    chk("sim_req_v", req_v_o, 1);
    chk("sim_done0", done_o, 0);
    tick();
    chk("sim_issued", issued_cnt_o, 1);
    chk("sim_done1", done_o, 0);
    resp_v_i = 1'b1;
    resp_data_i = 64'hABCD;
    tick();
    resp_v_i = 1'b0;
    chk("sim_done2", done_o, 0);
    chk("sim_idle", tr_ready_and_o, 1);
    tick();
    tr_done_i = 1'b0;
    chk("sim_done3", done_o, 1);
    chk("sim_err", error_o, 0);
    do_reset();
    req_ready_and_i = 1'b0;
    tr_pkt_i = {4'b1010, 40'h80000300, 1'b1, 64'h0123456789ABCDEF};
    tr_v_i = 1'b1;
    tick();
    tr_v_i = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk("bp_req_v", req_v_o, 1);
      chk("bp_cmd", req_cmd_o, 4'b1010);
      chk("bp_paddr", req_paddr_o, 40'h80000300);
      chk("bp_unc", req_uncached_o, 1);
      chk("bp_data", req_data_o, 64'h0123456789ABCDEF);
      chk("bp_timeout0", timeout_o, 0);
      tick();
    end
    chk("bp_last_req_v", req_v_o, 1);
    tick();
    chk("to_timeout", timeout_o, 1);
    chk("to_err", error_o, 1);
    chk("to_ready", tr_ready_and_o, 0);
    chk("to_req_v", req_v_o, 0);
    tr_v_i = 1'b1;
    req_ready_and_i = 1'b1;
    tick();
    tick();
    tr_v_i = 1'b0;
    chk("to_stay", timeout_o, 1);
    chk("to_req_v2", req_v_o, 0);
    chk("to_issued", issued_cnt_o, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
